pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 80 ++++++++
 tb/tb_pipe_reg_chain.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage, WIDTH-bit pipeline delay line with per-stage
// valid bits, stall (EN=0), flush, programmable reset value and live occupancy.
// All state updates happen on the CLK edge selected by NEG_EDGE.
module pipe_reg_chain #(
   parameter int               WIDTH       = 32,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               NEG_EDGE    = 1'b0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       EN,
   input  logic                       FLUSH,
   input  logic                       IN_VALID,
   input  logic [WIDTH-1:0]           D,
   output logic [WIDTH-1:0]           Q,
   output logic                       OUT_VALID,
   output logic [DEPTH-1:0]           STAGE_VALID,
   output logic [$clog2(DEPTH+1)-1:0] COUNT
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam int unsigned DEPTH_U = DEPTH;

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [CW-1:0]    cnt;

   // Next-state: RST and FLUSH both force the reset image, then EN shifts, else hold.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (RST || FLUSH) begin
         for (int unsigned i = 0; i < DEPTH_U; i++) begin
            data_d[i] = RESET_VALUE;
         end
         vld_d = '0;
      end else if (EN) begin
         data_d[0] = D;
         vld_d[0]  = IN_VALID;
         for (int unsigned i = 1; i < DEPTH_U; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
   end

   // Next-state logic is shared; only the capturing edge differs between the two branches.
   generate
      if (NEG_EDGE) begin : g_neg
         // Register the whole chain on the falling edge.
         always_ff @(negedge CLK) begin
            data_q <= data_d;
            vld_q  <= vld_d;
         end
      end else begin : g_pos
         // Register the whole chain on the rising edge.
         always_ff @(posedge CLK) begin
            data_q <= data_d;
            vld_q  <= vld_d;
         end
      end
   endgenerate

   // Occupancy: popcount of the valid bits, straight from the state registers.
   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
         cnt = cnt + CW'(vld_q[i]);
      end
   end

   assign Q           = data_q[DEPTH-1];
   assign OUT_VALID   = vld_q[DEPTH-1];
   assign STAGE_VALID = vld_q;
   assign COUNT       = cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: a posedge DEPTH=3 instance for the
// datapath features and a negedge DEPTH=1 instance for the flip-flop use.
module tb_pipe_reg_chain;

   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   int          total = 0;
   int          bad   = 0;

   // posedge instance signals
   logic        rst = 1'b1, flush = 1'b0, en = 1'b0, iv = 1'b0;
   logic [31:0] d = '0;
   logic [31:0] q;
   logic        ov;
   logic [2:0]  sv;
   logic [1:0]  cnt;

   // negedge instance signals
   logic        n_rst = 1'b1, n_flush = 1'b0, n_en = 1'b0, n_iv = 1'b0;
   logic [0:0]  n_d = '0;
   logic [0:0]  n_q;
   logic        n_ov;
   logic [0:0]  n_sv;
   logic [0:0]  n_cnt;

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(RV), .NEG_EDGE(1'b0)) dut (
      .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .IN_VALID(iv), .D(d),
      .Q(q), .OUT_VALID(ov), .STAGE_VALID(sv), .COUNT(cnt)
   );

   pipe_reg_chain #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1), .NEG_EDGE(1'b1)) dut_n (
      .CLK(clk), .RST(n_rst), .EN(n_en), .FLUSH(n_flush), .IN_VALID(n_iv), .D(n_d),
      .Q(n_q), .OUT_VALID(n_ov), .STAGE_VALID(n_sv), .COUNT(n_cnt)
   );

   // drive inputs on the falling edge, then sample 1 time unit after the rising edge
   task automatic step(input logic r, input logic f, input logic e, input logic v,
                       input logic [31:0] dv);
      @(negedge clk);
      rst = r; flush = f; en = e; iv = v; d = dv;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_5678);
      total++; if (q !== RV) begin bad++; $display("FAIL reset_q got=%h exp=%h", q, RV); end
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", ov); end
      total++; if (sv !== 3'b000) begin bad++; $display("FAIL reset_sv got=%b exp=000", sv); end
      total++; if (cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
   endtask

   task automatic test_streaming;
      logic [31:0] exp_q;
      logic [1:0]  exp_c;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 32'(k));
         exp_q = (k < 3) ? RV : 32'(k - 2);
         exp_c = (k < 3) ? 2'(k) : 2'd3;
         total++; if (q !== exp_q) begin bad++; $display("FAIL stream_q k=%0d got=%h exp=%h", k, q, exp_q); end
         total++; if (cnt !== exp_c) begin bad++; $display("FAIL stream_cnt k=%0d got=%0d exp=%0d", k, cnt, exp_c); end
      end
   endtask

   task automatic test_stall;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd10);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd11);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd12);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 32'd50 + 32'(k));
         total++; if (q !== 32'd10) begin bad++; $display("FAIL stall_q k=%0d got=%0d exp=10", k, q); end
         total++; if (sv !== 3'b111) begin bad++; $display("FAIL stall_sv k=%0d got=%b exp=111", k, sv); end
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd13);
      total++; if (q !== 32'd11) begin bad++; $display("FAIL stall_resume_q got=%0d exp=11", q); end
   endtask

   task automatic test_bubble;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd7);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd9);
      total++; if (sv !== 3'b101) begin bad++; $display("FAIL bubble_sv got=%b exp=101", sv); end
      total++; if (cnt !== 2'd2) begin bad++; $display("FAIL bubble_cnt got=%0d exp=2", cnt); end
      total++; if (q !== 32'd7 || ov !== 1'b1) begin bad++; $display("FAIL bubble_out0 got=%0d/%b exp=7/1", q, ov); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      total++; if (q !== 32'd8 || ov !== 1'b0) begin bad++; $display("FAIL bubble_out1 got=%0d/%b exp=8/0", q, ov); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      total++; if (q !== 32'd9 || ov !== 1'b1) begin bad++; $display("FAIL bubble_out2 got=%0d/%b exp=9/1", q, ov); end
   endtask

   // fill the pipe, kill it with FLUSH (use_rst=0) or RST (use_rst=1) while EN=1, D=99
   task automatic test_flush(input logic use_rst);
      logic [31:0] exp_q;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd20);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd21);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd22);
      step(use_rst, ~use_rst, 1'b1, 1'b1, 32'd99);
      total++; if (cnt !== 2'd0) begin bad++; $display("FAIL kill_cnt rst=%b got=%0d exp=0", use_rst, cnt); end
      total++; if (q !== RV || sv !== 3'b000) begin bad++; $display("FAIL kill_state rst=%b got=%h/%b exp=%h/000", use_rst, q, sv, RV); end
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd40);
      total++; if (sv !== 3'b001 || cnt !== 2'd1) begin bad++; $display("FAIL kill_resume rst=%b got=%b/%0d exp=001/1", use_rst, sv, cnt); end
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
         exp_q = (k < 2) ? RV : ((k == 2) ? 32'd40 : 32'd0);
         total++; if (q !== exp_q) begin bad++; $display("FAIL kill_drain rst=%b k=%0d got=%0d exp=%0d", use_rst, k, q, exp_q); end
      end
   endtask

   task automatic test_async_rst_pulse;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd5);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd6);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'd7);
      // glitch RST high while CLK is high, well clear of either edge
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      total++; if (q !== 32'd5 || cnt !== 2'd3) begin bad++; $display("FAIL async_rst got=%0d/%0d exp=5/3", q, cnt); end
   endtask

   task automatic test_negedge;
      @(posedge clk); #1;
      n_rst = 1'b1; n_en = 1'b0; n_flush = 1'b0; n_d = 1'b0; n_iv = 1'b0;
      @(negedge clk); #1;
      total++; if (n_q !== 1'b1 || n_ov !== 1'b0 || n_cnt !== 1'b0) begin bad++; $display("FAIL neg_reset got=%b/%b/%b exp=1/0/0", n_q, n_ov, n_cnt); end
      @(posedge clk); #1;
      n_rst = 1'b0; n_en = 1'b1; n_d = 1'b0; n_iv = 1'b1;
      #2;
      total++; if (n_q !== 1'b1) begin bad++; $display("FAIL neg_high_hold got=%b exp=1", n_q); end
      @(negedge clk); #1;
      total++; if (n_q !== 1'b0 || n_ov !== 1'b1 || n_sv !== 1'b1 || n_cnt !== 1'b1) begin bad++; $display("FAIL neg_capture got=%b/%b/%b/%b exp=0/1/1/1", n_q, n_ov, n_sv, n_cnt); end
      // present new data while CLK is low: the rising edge must not take it
      n_d = 1'b1; n_iv = 1'b0;
      @(posedge clk); #1;
      total++; if (n_q !== 1'b0 || n_ov !== 1'b1) begin bad++; $display("FAIL neg_no_posedge got=%b/%b exp=0/1", n_q, n_ov); end
      @(negedge clk); #1;
      total++; if (n_q !== 1'b1 || n_ov !== 1'b0) begin bad++; $display("FAIL neg_capture2 got=%b/%b exp=1/0", n_q, n_ov); end
      @(posedge clk); #1;
      n_d = 1'b0; n_iv = 1'b1; n_en = 1'b0;
      @(negedge clk); #1;
      total++; if (n_q !== 1'b1 || n_ov !== 1'b0) begin bad++; $display("FAIL neg_hold got=%b/%b exp=1/0", n_q, n_ov); end
      @(posedge clk); #1;
      n_en = 1'b1;
      @(negedge clk); #1;
      @(posedge clk); #1;
      n_flush = 1'b1; n_d = 1'b0;
      @(negedge clk); #1;
      total++; if (n_q !== 1'b1 || n_ov !== 1'b0) begin bad++; $display("FAIL neg_flush got=%b/%b exp=1/0", n_q, n_ov); end
      n_flush = 1'b0; n_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_stall();
      test_bubble();
      test_flush(1'b0);
      test_flush(1'b1);
      test_async_rst_pulse();
      test_negedge();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
